// File: rtl/instr_encoder.sv
// instr_encoder: turns field-level commands into RV32I words written sequentially to imem
module instr_encoder #(
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0,
  parameter int IMEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-2:0] word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  localparam logic [31:0] BASE_L = 32'(BASE_ADDR);
  localparam logic [31:0] LAST_L = 32'(BASE_ADDR + 4 * (IMEM_WORDS - 1));
  localparam logic [ADDR_W-1:0] BASE_A = BASE_L[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_A = LAST_L[ADDR_W-1:0];
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, out_addr_q, out_addr_d;
  logic [ADDR_W-2:0] word_count_q, word_count_d;
  logic [31:0] out_instr_q, out_instr_d, enc;
  logic out_valid_q, out_valid_d, done_q, done_d, err_q, err_d;
  logic [1:0] err_code_q, err_code_d, code;
  logic is_end, accept, emit, drain_ok;
  logic signed [31:0] simm;
  logic i_rng, b_rng, j_rng;
  assign simm  = in_imm;
  assign i_rng = simm < -32'sd2048 || simm > 32'sd2047;
  assign b_rng = simm < -32'sd4096 || simm > 32'sd4094;
  assign j_rng = simm < -32'sd1048576 || simm > 32'sd1048574;
  // Field packing per format plus the immediate legality verdict (0 = legal)
  always_comb begin
    enc    = '0;
    code   = 2'd0;
    is_end = 1'b0;
    case (in_fmt)
      4'd0:  enc = '0;
      4'd1:  begin enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011}; code = i_rng ? 2'd2 : 2'd0; end
      4'd2:  begin enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011}; code = i_rng ? 2'd2 : 2'd0; end
      4'd3:  enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd4:  begin enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011}; code = i_rng ? 2'd2 : 2'd0; end
      4'd5:  begin
        enc  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], 7'b1100011};
        code = b_rng ? 2'd2 : in_imm[0] ? 2'd3 : 2'd0;
      end
      4'd6:  begin
        enc  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        code = j_rng ? 2'd2 : in_imm[0] ? 2'd3 : 2'd0;
      end
      4'd7:  begin enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111}; code = i_rng ? 2'd2 : 2'd0; end
      4'd8:  begin enc = {in_imm[31:12], in_rd, 7'b0110111}; code = in_imm[11:0] != 12'd0 ? 2'd3 : 2'd0; end
      4'd9:  begin enc = {in_imm[31:12], in_rd, 7'b0010111}; code = in_imm[11:0] != 12'd0 ? 2'd3 : 2'd0; end
      4'd15: is_end = 1'b1;
      default: code = 2'd1;
    endcase
  end
  assign in_ready = state_q == LOAD && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = accept && !is_end && code == 2'd0;
  assign drain_ok = !out_valid_q || out_ready;
  // Session sequencing, single output register with hold-until-ready, error pulses
  always_comb begin
    state_d      = state_q == IDLE ? (start ? LOAD : IDLE)
                 : state_q == LOAD ? ((accept && is_end) || (emit && addr_q == LAST_A) ? DRAIN : LOAD)
                 : (drain_ok ? IDLE : DRAIN);
    addr_d       = state_q == IDLE && start ? {start_addr[ADDR_W-1:2], 2'b00}
                 : emit ? addr_q + ADDR_W'(4) : addr_q;
    word_count_d = state_q == IDLE && start ? '0
                 : emit ? word_count_q + (ADDR_W-1)'(1) : word_count_q;
    out_valid_d  = emit || (out_valid_q && !out_ready);
    out_instr_d  = emit ? enc : out_instr_q;
    out_addr_d   = emit ? addr_q : out_addr_q;
    done_d       = state_q == DRAIN && drain_ok;
    err_d        = accept && code != 2'd0;
    err_code_d   = err_d ? code : err_code_q;
  end
  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= BASE_A;
      word_count_q <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= BASE_A;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign busy       = state_q == LOAD;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign word_count = word_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench for instr_encoder against a field-rule model
module tb_instr_encoder;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [11:0] start_addr = 0;
  logic [3:0] in_fmt = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [2:0] in_funct3 = 0;
  logic [6:0] in_funct7 = 0;
  logic [31:0] in_imm = 0;
  logic in_ready, out_valid, busy, done, err;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic [1:0] err_code;
  logic [10:0] word_count;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, done_cnt = 0, m_addr = 0, m_cnt = 0;
  bit m_load = 0, stall = 0, all_rdy = 0;
  logic [43:0] wq[$];
  int eq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference encoding: place each instruction field at its ISA bit position
  function automatic logic [31:0] model_enc(input int f, input logic [31:0] rd, rs1, rs2, f3, f7, imm);
    case (f)
      1, 4, 7: return (bits(imm, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | (f == 1 ? 32'h03 : f == 4 ? 32'h13 : 32'h67);
      2: return (bits(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (bits(imm, 4, 0) << 7) | 32'h23;
      3: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      5: return (bits(imm, 12, 12) << 31) | (bits(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | (bits(imm, 4, 1) << 8) | (bits(imm, 11, 11) << 7) | 32'h63;
      6: return (bits(imm, 20, 20) << 31) | (bits(imm, 10, 1) << 21) | (bits(imm, 11, 11) << 20)
              | (bits(imm, 19, 12) << 12) | (rd << 7) | 32'h6f;
      8: return (imm & 32'hfffff000) | (rd << 7) | 32'h37;
      9: return (imm & 32'hfffff000) | (rd << 7) | 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_code(input int f, input logic [31:0] imm);
    int v = imm;
    if (f == 1 || f == 2 || f == 4 || f == 7) return (v < -2048 || v > 2047) ? 2 : 0;
    if (f == 5) return (v < -4096 || v > 4094) ? 2 : imm[0] ? 3 : 0;
    if (f == 6) return (v < -(1 << 20) || v > (1 << 20) - 2) ? 2 : imm[0] ? 3 : 0;
    if (f == 8 || f == 9) return imm[11:0] != 12'd0 ? 3 : 0;
    if (f == 0 || f == 3 || f == 15) return 0;
    return 1;
  endfunction

  // Monitor: drives out_ready, pops the scoreboard on each handshake, checks err pulses
  always @(negedge clk) begin
    logic [43:0] w;
    out_ready = stall ? 1'b0 : all_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (out_valid && out_ready) begin
      if (wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected word: got %h at %h, expected none", out_instr, out_addr);
      end else begin
        w = wq.pop_front();
        check("out_instr", out_instr, w[31:0]);
        check("out_addr", {20'd0, out_addr}, {20'd0, w[43:32]});
      end
    end
    if (err) begin
      if (eq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected err: got code %0d, expected no err", err_code);
      end else check("err_code", {30'd0, err_code}, eq.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic start_session(input int a);
    @(negedge clk);
    start = 1; start_addr = 12'(a);
    @(posedge clk); #1;
    start = 0;
    m_addr = a & ~3; m_cnt = 0; m_load = 1;
  endtask

  task automatic send(input int f, rd, rs1, rs2, f3, f7, input logic [31:0] imm, input int budget, output bit acc);
    int c;
    bit rdy;
    acc = 0;
    @(negedge clk);
    in_fmt = 4'(f); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm; in_valid = 1;
    for (int i = 0; i < budget; i++) begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) begin acc = 1; break; end
      @(negedge clk);
    end
    if (acc) begin
      c = model_code(f, imm);
      if (f == 15) m_load = 0;
      else if (c != 0) eq.push_back(c);
      else begin
        wq.push_back({12'(m_addr), model_enc(f, rd, rs1, rs2, f3, f7, imm)});
        m_addr += 4; m_cnt++;
        if (m_addr == 4096) m_load = 0;
      end
    end
    #1 in_valid = 0;
  endtask

  task automatic cmd(input int f, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
    bit acc;
    send(f, rd, rs1, rs2, f3, f7, imm, 200, acc);
    check("accept", {31'd0, acc}, 1);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (done_cnt > d0) break;
    end
    @(posedge clk); #2;
    check("done pulse count", done_cnt, d0 + 1);
    check("busy after done", {31'd0, busy}, 0);
    check("word_count", {21'd0, word_count}, m_cnt);
    check("scoreboard drained", wq.size(), 0);
  endtask

  initial begin
    int f, r, d0;
    logic [31:0] imm;
    bit acc;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int f, r, d0;
    logic [31:0] imm;
    bit acc;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst in_ready", {31'd0, in_ready}, 0);
    check("rst out_valid", {31'd0, out_valid}, 0);
    check("rst out_instr", out_instr, 0);
    check("rst out_addr", {20'd0, out_addr}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst done/err", {30'd0, done, err}, 0);
    check("rst err_code", {30'd0, err_code}, 0);
    check("rst word_count", {21'd0, word_count}, 0);
    rst_n = 1;

    // Basic IALU latency, then back-to-back STORE/BRANCH with out_ready held high
    all_rdy = 1;
    d0 = done_cnt;
    start_session(32'h100);
    cmd(4, 1, 0, 0, 0, 0, 32'd5);
    check("ialu out_valid", {31'd0, out_valid}, 1);
    check("ialu out_instr", out_instr, 32'h00500093);
    check("ialu out_addr", {20'd0, out_addr}, 32'h100);
    check("ialu word_count", {21'd0, word_count}, 1);
    cmd(2, 0, 1, 2, 2, 0, 32'd8);
    check("store out_instr", out_instr, 32'h0020A423);
    cmd(5, 0, 1, 2, 0, 0, 32'd8);
    check("branch out_instr", out_instr, 32'h00208463);
    check("branch out_addr", {20'd0, out_addr}, 32'h108);
    cmd(15, 0, 0, 0, 0, 0, 0);
    wait_done(d0);
    all_rdy = 0;

    // Output stall holds the word and blocks a queued command
    d0 = done_cnt;
    start_session(32'h502);
    stall = 1;
    cmd(8, 5, 0, 0, 0, 0, 32'h12345000);
    in_fmt = 4'd4; in_rd = 5'd3; in_rs1 = 5'd2; in_imm = 32'd7; in_funct3 = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("stall out_valid", {31'd0, out_valid}, 1);
      check("stall out_instr", out_instr, 32'h123452B7);
      check("stall out_addr", {20'd0, out_addr}, 32'h500);
      check("stall in_ready", {31'd0, in_ready}, 0);
    end
    stall = 0;
    cmd(4, 3, 2, 0, 0, 0, 32'd7);
    cmd(15, 0, 0, 0, 0, 0, 0);
    wait_done(d0);

    // Rejected commands leave addr and word_count untouched
    d0 = done_cnt;
    start_session(32'h400);
    cmd(5, 0, 1, 2, 0, 0, 32'd3);
    cmd(4, 1, 1, 0, 0, 0, 32'd4096);
    cmd(12, 1, 1, 1, 0, 0, 32'd0);
    cmd(6, 0, 0, 0, 0, 0, 32'h00200000);
    cmd(4, 9, 8, 0, 3, 0, 32'hfffff800);
    repeat (3) @(posedge clk);
    check("err_code held", {30'd0, err_code}, 2);
    cmd(15, 0, 0, 0, 0, 0, 0);
    wait_done(d0);

    // Randomized session against the reference model
    d0 = done_cnt;
    start_session(32'h200);
    for (int n = 0; n < 60; n++) begin
      f = $urandom_range(0, 15);
      if (f == 15) f = 3;
      r = $urandom_range(0, 4);
      imm = r == 0 ? 32'($urandom_range(0, 4095)) - 32'd2048
          : r == 1 ? $urandom
          : r == 2 ? ($urandom & 32'hfffff000)
          : r == 3 ? 32'($urandom_range(0, 8199)) - 32'd4100
          : 32'($urandom_range(0, 32'h200004)) - 32'h100002;
      cmd(f, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 7), $urandom_range(0, 127), imm);
    end
    cmd(15, 0, 0, 0, 0, 0, 0);
    wait_done(d0);

    // Capacity limit: the last word ends the session, no wrap
    d0 = done_cnt;
    start_session(4096 - 16);
    for (int i = 0; i < 4; i++) cmd(4, i + 1, i, 0, 0, 0, 32'(i));
    send(4, 7, 7, 0, 0, 0, 32'd1, 10, acc);
    check("capacity fifth rejected", {31'd0, acc}, 0);
    wait_done(d0);

    // Reset with a stalled word pending drops it silently
    start_session(32'h300);
    stall = 1;
    cmd(4, 2, 2, 0, 0, 0, 32'd9);
    @(negedge clk); #1;
    check("pre-reset out_valid", {31'd0, out_valid}, 1);
    d0 = done_cnt;
    rst_n = 0;
    @(posedge clk); #1;
    check("reset out_valid", {31'd0, out_valid}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset out_addr", {20'd0, out_addr}, 0);
    wq.delete();
    rst_n = 1;
    stall = 0;
    repeat (4) @(posedge clk);
    #2 check("no done after reset", done_cnt, d0);
    check("err queue empty", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
